// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Program loader for the single-cycle core's instruction memory.
//             Consumes a header-prefixed word stream (header = word count N,
//             followed by N instruction words) over valid/ready and issues
//             one instruction-memory write per word. The core is held out of
//             run until the whole program has been written.
//  Ports    : clk_i, rst_n_i         - clock (rising edge), async active-low reset
//             start_i                - begin a load (accepted in IDLE and RUN)
//             s_valid_i, s_data_i    - stream word in
//             s_ready_o              - loader accepts a word this cycle
//             enable_wimem_o         - one-cycle write strobe per word
//             imem_addr_o, imem_wdata_o - write address / data
//             cpu_run_o              - core released (low = core held)
//             busy_o, done_o, err_o  - load status
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              enable_wimem_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              cpu_run_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Memory depth expressed at full stream-word width so the header is
    // range-checked against every bit, not just the low ADDR_W+1 bits.
    localparam logic [DATA_W-1:0] DEPTH = DATA_W'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              handshake;
    logic              hdr_bad;

    assign handshake = s_valid_i & s_ready_o;
    assign hdr_bad   = (s_data_i == '0) || (s_data_i > DEPTH);

    // Status outputs decoded purely from the state register.
    assign s_ready_o = (state == ST_LEN) || (state == ST_LOAD);
    assign busy_o    = (state == ST_LEN) || (state == ST_LOAD) || (state == ST_FLUSH);
    assign cpu_run_o = (state == ST_RUN);
    assign done_o    = (state == ST_RUN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_IDLE;
            addr           <= '0;
            remaining      <= '0;
            enable_wimem_o <= 1'b0;
            imem_addr_o    <= '0;
            imem_wdata_o   <= '0;
            err_o          <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            enable_wimem_o <= 1'b0;

            case (state)
                ST_IDLE, ST_RUN: begin
                    if (start_i) begin
                        state <= ST_LEN;
                        err_o <= 1'b0;
                    end
                end

                ST_LEN: begin
                    if (handshake) begin
                        if (hdr_bad) begin
                            state <= ST_IDLE;
                            err_o <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            remaining <= s_data_i[ADDR_W:0];
                            addr      <= '0;
                        end
                    end
                end

                ST_LOAD: begin
                    if (handshake) begin
                        enable_wimem_o <= 1'b1;
                        imem_addr_o    <= addr;
                        imem_wdata_o   <= s_data_i;
                        // addr may roll over after the last word of a full
                        // load, but no further write is ever issued from it.
                        addr           <= addr + 1'b1;
                        remaining      <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= ST_FLUSH;
                        end
                    end
                end

                // One cycle in which the final write pulse is presented.
                ST_FLUSH: begin
                    state <= ST_RUN;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes instruction words into instruction memory before the single-cycle core fetches from it.
- The core-side control path reads and decodes instructions; this block is the writer at the other end of that instruction-memory interface.
- Accepts a header-prefixed word stream over a valid/ready handshake and issues one instruction-memory write per word.
- Holds the core out of run until the program is fully loaded.

Parameters:
ADDR_W, 6, instruction-memory word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse: begin a load (honoured in IDLE and RUN only)
s_valid_i  input  1  stream word valid
s_data_i  input  DATA_W  stream word (header first, then instructions)
s_ready_o  output  1  loader accepts a word this cycle
enable_wimem_o  output  1  instruction-memory write enable, one-cycle pulse per word
imem_addr_o  output  ADDR_W  instruction-memory word address
imem_wdata_o  output  DATA_W  instruction-memory write data
cpu_run_o  output  1  core released; low holds the core in reset
busy_o  output  1  load in progress (LEN, LOAD or FLUSH)
done_o  output  1  load completed successfully; level signal
err_o  output  1  bad header; sticky until the next start_i

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; every output 0; internal counter 0.
- States: IDLE, LEN, LOAD, FLUSH, RUN. All outputs are registered or decoded from the state register only.
- s_ready_o is 1 only in LEN and LOAD.
- A handshake occurs when s_valid_i & s_ready_o on a rising edge.
- IDLE / RUN:
  - start_i=1 -> LEN. Next cycle: cpu_run_o=0, done_o=0, err_o=0, busy_o=1.
  - start_i is ignored in LEN, LOAD and FLUSH.
- LEN, on handshake, N = s_data_i compared as a full unsigned DATA_W value:
  - N==0 or N>2**ADDR_W -> IDLE. Next cycle: err_o=1, busy_o=0. No write issued.
  - Otherwise -> LOAD, with remaining=N (ADDR_W+1 bits) and address=0.
- LOAD, on each handshake:
  - Next cycle: enable_wimem_o=1 for exactly one cycle, imem_addr_o = current address, imem_wdata_o = s_data_i.
  - address increments by 1; remaining decrements by 1.
  - The handshake with remaining==1 goes to FLUSH.
  - No handshake (s_valid_i=0): no write, state and counters hold.
- Write latency is one cycle after the handshake. Back-to-back handshakes give back-to-back write pulses.
- FLUSH (one cycle): the final write pulse is visible; s_ready_o=0. Then -> RUN.
- RUN: cpu_run_o=1, done_o=1, busy_o=0. The first RUN cycle is 2 cycles after the final handshake.
- Address never wraps. N==2**ADDR_W writes addresses 0..2**ADDR_W-1 exactly.
- Between writes imem_addr_o and imem_wdata_o hold their last values; they are meaningful only while enable_wimem_o=1.
- Reset mid-load: immediate return to IDLE with all outputs 0. Partial memory contents are undefined; the core stays held (cpu_run_o=0).
- Re-load from RUN: start_i drops cpu_run_o and done_o on the next edge, then the sequence restarts.

Test Plan:
1. start_i; stream N=3, then 0x20080005, 0x20090007, 0x01095020 back-to-back -> write pulses at addr 0,1,2 with those data on the cycle after each handshake; cpu_run_o=done_o=1 exactly 2 cycles after the last handshake.
2. Same load with s_valid_i low for 2 cycles between every word -> the same 3 writes, no extra or duplicate pulses; s_ready_o stays 1 throughout LOAD.
3. Header N=0, then separately N=65 with ADDR_W=6 -> err_o=1 the cycle after the header, no write pulse, cpu_run_o=0, next start_i clears err_o.
4. N=64 with ADDR_W=6 -> 64 writes, last at addr 63, no wrap, then done_o=1.
5. Deassert rst_n_i asynchronously after the 2nd word of N=5 -> all outputs 0 immediately; after release the state is IDLE and s_ready_o=0.
6. From RUN, pulse start_i and load N=1 -> cpu_run_o and done_o fall on the next edge; start_i during LOAD has no effect; RUN is re-entered after one write.
